// File: rtl/mem_stage_if.sv
// Bundle of EX/MEM inputs, data-bus handshake and write-back outputs of the memory stage.
// master drives the upstream bundle and bus acks; slave is the memory stage itself.
interface mem_stage_if;
    logic [1:0]       in_valid;
    logic [1:0]       in_load;
    logic [1:0]       in_store;
    logic [1:0][1:0]  in_size;
    logic [1:0]       in_sign;
    logic [1:0][31:0] in_addr;
    logic [1:0][31:0] in_wdata;
    logic [1:0][31:0] in_alu;
    logic [1:0][4:0]  in_wreg;

    logic             stall_req;

    logic             data_req;
    logic             data_wr;
    logic [31:0]      data_addr;
    logic [31:0]      data_wdata;
    logic [3:0]       data_wstrb;
    logic             data_addr_ok;
    logic             data_data_ok;
    logic [31:0]      data_rdata;

    logic [1:0]       wb_valid;
    logic [1:0][4:0]  wb_reg;
    logic [1:0][31:0] wb_data;
    logic [1:0]       wb_exc;

    modport master (
        output in_valid, in_load, in_store, in_size, in_sign,
        output in_addr, in_wdata, in_alu, in_wreg,
        output data_addr_ok, data_data_ok, data_rdata,
        input  stall_req, data_req, data_wr, data_addr, data_wdata, data_wstrb,
        input  wb_valid, wb_reg, wb_data, wb_exc
    );

    modport slave (
        input  in_valid, in_load, in_store, in_size, in_sign,
        input  in_addr, in_wdata, in_alu, in_wreg,
        input  data_addr_ok, data_data_ok, data_rdata,
        output stall_req, data_req, data_wr, data_addr, data_wdata, data_wstrb,
        output wb_valid, wb_reg, wb_data, wb_exc
    );
endinterface

// File: rtl/mem_stage.sv
// Dual-issue memory stage: serialises up to two loads/stores onto a single data bus
// and produces a registered write-back bundle, stalling EX/MEM while the bus is busy.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    localparam int unsigned NSLOT = 2;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned STRBW = 4;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                      state_q;
    logic                        k_q;
    logic [NSLOT-1:0][XLEN-1:0]  ld_q;

    logic                        req_q;
    logic                        wr_q;
    logic [XLEN-1:0]             addr_q;
    logic [XLEN-1:0]             wdata_q;
    logic [STRBW-1:0]            wstrb_q;

    logic [NSLOT-1:0]            wb_valid_q;
    logic [NSLOT-1:0]            wb_exc_q;
    logic [NSLOT-1:0][4:0]       wb_reg_q;
    logic [NSLOT-1:0][XLEN-1:0]  wb_data_q;

    logic [NSLOT-1:0]            mem_raw;
    logic [NSLOT-1:0]            is_st;
    logic [NSLOT-1:0]            misal;
    logic [NSLOT-1:0]            exc;
    logic [NSLOT-1:0]            mem_op;
    logic [NSLOT-1:0]            wbv;
    logic [NSLOT-1:0][4:0]       wbr;
    logic [NSLOT-1:0][XLEN-1:0]  wbd;

    logic                        req_sel;
    logic                        go_req;
    logic [1:0]                  req_a;
    logic [1:0]                  req_sz;
    logic [XLEN-1:0]             req_wd;
    logic [STRBW-1:0]            req_strb;
    logic [XLEN-1:0]             req_wdat;

    logic [1:0]                  ld_a;
    logic [1:0]                  ld_sz;
    logic                        ld_sg;
    logic [XLEN-1:0]             ld_sh;
    logic [XLEN-1:0]             ld_fmt;

    logic                        stall_c;

    // Slot classification; a misaligned slot 0 kills slot 1 entirely.
    always_comb begin
        for (int i = 0; i < int'(NSLOT); i++) begin
            mem_raw[i] = bus.in_valid[i] & (bus.in_load[i] | bus.in_store[i]);
            is_st[i]   = bus.in_store[i] & ~bus.in_load[i];
            misal[i]   = mem_raw[i] &
                         (((bus.in_size[i] == 2'd1) & bus.in_addr[i][0]) |
                          (bus.in_size[i][1] & (bus.in_addr[i][1:0] != 2'd0)));
        end
        exc[0]    = misal[0];
        exc[1]    = misal[1] & ~misal[0];
        mem_op[0] = mem_raw[0] & ~misal[0];
        mem_op[1] = mem_raw[1] & ~misal[1] & ~misal[0];
        wbv[0]    = bus.in_valid[0] & ~exc[0];
        wbv[1]    = bus.in_valid[1] & ~exc[1] & ~misal[0];
        for (int i = 0; i < int'(NSLOT); i++) begin
            wbr[i] = (wbv[i] & ~is_st[i]) ? bus.in_wreg[i] : 5'd0;
            wbd[i] = (mem_op[i] & ~is_st[i]) ? ld_q[i] : bus.in_alu[i];
        end
    end

    // Bus request for the slot about to enter REQ: lowest mem op from IDLE, slot 1 from WAIT.
    always_comb begin
        req_sel = (state_q == IDLE) ? ~mem_op[0] : 1'b1;
        go_req  = ((state_q == IDLE) & (|mem_op)) |
                  ((state_q == WAIT) & bus.data_data_ok & ~k_q & mem_op[1]);
        req_a   = bus.in_addr[req_sel][1:0];
        req_sz  = bus.in_size[req_sel];
        req_wd  = bus.in_wdata[req_sel];
        if (req_sz == 2'd0) begin
            req_strb = STRBW'(4'b0001 << req_a);
            req_wdat = {4{req_wd[7:0]}};
        end else if (req_sz == 2'd1) begin
            req_strb = STRBW'(4'b0011 << req_a);
            req_wdat = {2{req_wd[15:0]}};
        end else begin
            req_strb = 4'b1111;
            req_wdat = req_wd;
        end
        if (!is_st[req_sel]) begin
            req_strb = '0;
        end
    end

    // Load lane select and extension for the active slot.
    always_comb begin
        ld_a  = bus.in_addr[k_q][1:0];
        ld_sz = bus.in_size[k_q];
        ld_sg = bus.in_sign[k_q];
        ld_sh = bus.data_rdata >> {ld_a, 3'b000};
        if (ld_sz == 2'd0) begin
            ld_fmt = {{24{ld_sg & ld_sh[7]}}, ld_sh[7:0]};
        end else if (ld_sz == 2'd1) begin
            ld_fmt = {{16{ld_sg & ld_sh[15]}}, ld_sh[15:0]};
        end else begin
            ld_fmt = ld_sh;
        end
    end

    // Must react in the same cycle a mem op shows up, otherwise EX/MEM would advance past it.
    assign stall_c = ((state_q == IDLE) & (|mem_op)) | (state_q == REQ) | (state_q == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= 1'b0;
            ld_q       <= '0;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wb_valid_q <= '0;
            wb_exc_q   <= '0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|mem_op) begin
                        k_q     <= req_sel;
                        state_q <= REQ;
                    end else begin
                        wb_valid_q <= wbv;
                        wb_exc_q   <= exc;
                        wb_reg_q   <= wbr;
                        wb_data_q  <= wbd;
                    end
                end
                REQ: begin
                    // data_data_ok alongside addr_ok is deliberately ignored here.
                    if (bus.data_addr_ok) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.data_data_ok) begin
                        if (!is_st[k_q]) begin
                            ld_q[k_q] <= ld_fmt;
                        end
                        if (!k_q && mem_op[1]) begin
                            k_q     <= 1'b1;
                            state_q <= REQ;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    wb_valid_q <= wbv;
                    wb_exc_q   <= exc;
                    wb_reg_q   <= wbr;
                    wb_data_q  <= wbd;
                    k_q        <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (go_req) begin
                req_q   <= 1'b1;
                wr_q    <= is_st[req_sel];
                addr_q  <= bus.in_addr[req_sel];
                wdata_q <= req_wdat;
                wstrb_q <= req_strb;
            end
        end
    end

    assign bus.stall_req  = stall_c;
    assign bus.data_req   = req_q;
    assign bus.data_wr    = wr_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;
    assign bus.data_wstrb = wstrb_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_exc     = wb_exc_q;
    assign bus.wb_reg     = wb_reg_q;
    assign bus.wb_data    = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU pass-through, loads/stores, misalignment, reset abort.
module tb_mem_stage;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    mem_stage_if bus ();

    mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        bus.in_valid     = '0;
        bus.in_load      = '0;
        bus.in_store     = '0;
        bus.in_size      = '0;
        bus.in_sign      = '0;
        bus.in_addr      = '0;
        bus.in_wdata     = '0;
        bus.in_alu       = '0;
        bus.in_wreg      = '0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = '0;
    endtask

    task automatic test_reset;
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_chk++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", bus.stall_req); end
        n_chk++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", bus.data_req); end
        n_chk++; if (bus.wb_valid !== 2'b00) begin n_fail++; $display("FAIL reset_wb_valid got %b exp 00", bus.wb_valid); end
        n_chk++; if (bus.wb_exc !== 2'b00) begin n_fail++; $display("FAIL reset_wb_exc got %b exp 00", bus.wb_exc); end
        n_chk++; if (bus.wb_data !== 64'h0) begin n_fail++; $display("FAIL reset_wb_data got %h exp 0", bus.wb_data); end
        n_chk++; if (bus.wb_reg !== 10'h0) begin n_fail++; $display("FAIL reset_wb_reg got %h exp 0", bus.wb_reg); end
    endtask

    task automatic test_alu;
        clear_in();
        bus.in_valid   = 2'b11;
        bus.in_wreg[0] = 5'd3;
        bus.in_wreg[1] = 5'd4;
        bus.in_alu[0]  = 32'd5;
        bus.in_alu[1]  = 32'd6;
        #1;
        n_chk++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b exp 0", bus.stall_req); end
        tick();
        n_chk++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL alu_stall2 got %b exp 0", bus.stall_req); end
        n_chk++; if (bus.wb_valid !== 2'b11) begin n_fail++; $display("FAIL alu_wb_valid got %b exp 11", bus.wb_valid); end
        n_chk++; if (bus.wb_data[0] !== 32'd5 || bus.wb_data[1] !== 32'd6) begin n_fail++; $display("FAIL alu_wb_data got %h/%h exp 5/6", bus.wb_data[0], bus.wb_data[1]); end
        n_chk++; if (bus.wb_reg[0] !== 5'd3 || bus.wb_reg[1] !== 5'd4) begin n_fail++; $display("FAIL alu_wb_reg got %0d/%0d exp 3/4", bus.wb_reg[0], bus.wb_reg[1]); end
    endtask

    task automatic test_lb_sign;
        clear_in();
        bus.in_valid[0]  = 1'b1;
        bus.in_load[0]   = 1'b1;
        bus.in_size[0]   = 2'd0;
        bus.in_sign[0]   = 1'b1;
        bus.in_addr[0]   = 32'h0000_1003;
        bus.in_wreg[0]   = 5'd7;
        #1;
        n_chk++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL lb_stall_idle got %b exp 1", bus.stall_req); end
        tick();
        n_chk++; if (bus.data_req !== 1'b1 || bus.data_wr !== 1'b0) begin n_fail++; $display("FAIL lb_req got req=%b wr=%b exp 1/0", bus.data_req, bus.data_wr); end
        n_chk++; if (bus.data_addr !== 32'h0000_1003 || bus.data_wstrb !== 4'b0000) begin n_fail++; $display("FAIL lb_addr got %h strb %b exp 00001003/0000", bus.data_addr, bus.data_wstrb); end
        tick();
        n_chk++; if (bus.data_req !== 1'b1 || bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL lb_req_hold got req=%b stall=%b exp 1/1", bus.data_req, bus.stall_req); end
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        n_chk++; if (bus.data_req !== 1'b0 || bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL lb_wait got req=%b stall=%b exp 0/1", bus.data_req, bus.stall_req); end
        n_chk++; if (bus.wb_valid !== 2'b11 || bus.wb_data[0] !== 32'd5) begin n_fail++; $display("FAIL lb_wb_hold got %b/%h exp 11/5", bus.wb_valid, bus.wb_data[0]); end
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h8012_3456;
        tick();
        bus.data_data_ok = 1'b0;
        n_chk++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL lb_done_stall got %b exp 0", bus.stall_req); end
        tick();
        clear_in();
        n_chk++; if (bus.wb_valid !== 2'b01) begin n_fail++; $display("FAIL lb_wb_valid got %b exp 01", bus.wb_valid); end
        n_chk++; if (bus.wb_data[0] !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_wb_data got %h exp ffffff80", bus.wb_data[0]); end
        n_chk++; if (bus.wb_reg[0] !== 5'd7) begin n_fail++; $display("FAIL lb_wb_reg got %0d exp 7", bus.wb_reg[0]); end
    endtask

    task automatic test_sh_lw;
        clear_in();
        bus.in_valid    = 2'b11;
        bus.in_store[0] = 1'b1;
        bus.in_size[0]  = 2'd1;
        bus.in_addr[0]  = 32'h0000_2002;
        bus.in_wdata[0] = 32'h0000_BEEF;
        bus.in_wreg[0]  = 5'd12;
        bus.in_load[1]  = 1'b1;
        bus.in_size[1]  = 2'd2;
        bus.in_addr[1]  = 32'h0000_3000;
        bus.in_wreg[1]  = 5'd9;
        tick();
        n_chk++; if (bus.data_req !== 1'b1 || bus.data_wr !== 1'b1 || bus.data_addr !== 32'h0000_2002) begin n_fail++; $display("FAIL sh_req got req=%b wr=%b addr=%h exp 1/1/00002002", bus.data_req, bus.data_wr, bus.data_addr); end
        n_chk++; if (bus.data_wstrb !== 4'b1100 || bus.data_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_lanes got strb=%b wdata=%h exp 1100/beefbeef", bus.data_wstrb, bus.data_wdata); end
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        tick();
        n_chk++; if (bus.data_req !== 1'b0 || bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL sh_same_cycle_ok got req=%b stall=%b exp 0/1", bus.data_req, bus.stall_req); end
        bus.data_data_ok = 1'b1;
        tick();
        bus.data_data_ok = 1'b0;
        n_chk++; if (bus.data_req !== 1'b1 || bus.data_wr !== 1'b0 || bus.data_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL lw_req got req=%b wr=%b addr=%h exp 1/0/00003000", bus.data_req, bus.data_wr, bus.data_addr); end
        n_chk++; if (bus.data_wstrb !== 4'b0000) begin n_fail++; $display("FAIL lw_strb got %b exp 0000", bus.data_wstrb); end
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h1234_5678;
        tick();
        bus.data_data_ok = 1'b0;
        n_chk++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL shlw_done_stall got %b exp 0", bus.stall_req); end
        tick();
        clear_in();
        n_chk++; if (bus.wb_valid !== 2'b11) begin n_fail++; $display("FAIL shlw_wb_valid got %b exp 11", bus.wb_valid); end
        n_chk++; if (bus.wb_reg[0] !== 5'd0 || bus.wb_reg[1] !== 5'd9) begin n_fail++; $display("FAIL shlw_wb_reg got %0d/%0d exp 0/9", bus.wb_reg[0], bus.wb_reg[1]); end
        n_chk++; if (bus.wb_data[1] !== 32'h1234_5678) begin n_fail++; $display("FAIL shlw_wb_data got %h exp 12345678", bus.wb_data[1]); end
    endtask

    task automatic test_sb_slot1;
        clear_in();
        bus.in_valid    = 2'b11;
        bus.in_alu[0]   = 32'h0000_0042;
        bus.in_wreg[0]  = 5'd2;
        bus.in_store[1] = 1'b1;
        bus.in_size[1]  = 2'd0;
        bus.in_addr[1]  = 32'h0000_7001;
        bus.in_wdata[1] = 32'h1122_335A;
        bus.in_wreg[1]  = 5'd8;
        tick();
        n_chk++; if (bus.data_addr !== 32'h0000_7001 || bus.data_wstrb !== 4'b0010 || bus.data_wdata !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL sb_req got addr=%h strb=%b wdata=%h exp 00007001/0010/5a5a5a5a", bus.data_addr, bus.data_wstrb, bus.data_wdata); end
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        tick();
        bus.data_data_ok = 1'b0;
        tick();
        clear_in();
        n_chk++; if (bus.wb_valid !== 2'b11 || bus.wb_reg[0] !== 5'd2 || bus.wb_reg[1] !== 5'd0) begin n_fail++; $display("FAIL sb_wb got valid=%b reg=%0d/%0d exp 11/2/0", bus.wb_valid, bus.wb_reg[0], bus.wb_reg[1]); end
        n_chk++; if (bus.wb_data[0] !== 32'h0000_0042) begin n_fail++; $display("FAIL sb_wb_data got %h exp 00000042", bus.wb_data[0]); end
    endtask

    task automatic test_lh_zero;
        clear_in();
        bus.in_valid[0] = 1'b1;
        bus.in_load[0]  = 1'b1;
        bus.in_size[0]  = 2'd1;
        bus.in_sign[0]  = 1'b0;
        bus.in_addr[0]  = 32'h0000_6002;
        bus.in_wreg[0]  = 5'd10;
        tick();
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hABCD_1234;
        tick();
        bus.data_data_ok = 1'b0;
        tick();
        clear_in();
        n_chk++; if (bus.wb_valid !== 2'b01 || bus.wb_data[0] !== 32'h0000_ABCD) begin n_fail++; $display("FAIL lhu_wb got valid=%b data=%h exp 01/0000abcd", bus.wb_valid, bus.wb_data[0]); end
    endtask

    task automatic test_misaligned;
        clear_in();
        bus.in_valid   = 2'b11;
        bus.in_load[0] = 1'b1;
        bus.in_size[0] = 2'd2;
        bus.in_addr[0] = 32'h0000_4001;
        bus.in_wreg[0] = 5'd5;
        bus.in_load[1] = 1'b1;
        bus.in_size[1] = 2'd2;
        bus.in_addr[1] = 32'h0000_4004;
        bus.in_wreg[1] = 5'd6;
        #1;
        n_chk++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL mis0_stall got %b exp 0", bus.stall_req); end
        tick();
        n_chk++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL mis0_req got %b exp 0", bus.data_req); end
        n_chk++; if (bus.wb_exc !== 2'b01 || bus.wb_valid !== 2'b00) begin n_fail++; $display("FAIL mis0_wb got exc=%b valid=%b exp 01/00", bus.wb_exc, bus.wb_valid); end
        clear_in();
        bus.in_valid   = 2'b11;
        bus.in_alu[0]  = 32'd77;
        bus.in_wreg[0] = 5'd1;
        bus.in_load[1] = 1'b1;
        bus.in_size[1] = 2'd1;
        bus.in_addr[1] = 32'h0000_5003;
        bus.in_wreg[1] = 5'd6;
        #1;
        n_chk++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL mis1_stall got %b exp 0", bus.stall_req); end
        tick();
        clear_in();
        n_chk++; if (bus.wb_exc !== 2'b10 || bus.wb_valid !== 2'b01 || bus.wb_data[0] !== 32'd77) begin n_fail++; $display("FAIL mis1_wb got exc=%b valid=%b data=%h exp 10/01/0000004d", bus.wb_exc, bus.wb_valid, bus.wb_data[0]); end
    endtask

    task automatic test_rst_wait;
        clear_in();
        bus.in_valid[0] = 1'b1;
        bus.in_load[0]  = 1'b1;
        bus.in_size[0]  = 2'd2;
        bus.in_addr[0]  = 32'h0000_5000;
        bus.in_wreg[0]  = 5'd11;
        tick();
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        n_chk++; if (bus.stall_req !== 1'b1 || bus.data_req !== 1'b0) begin n_fail++; $display("FAIL rstw_in_wait got stall=%b req=%b exp 1/0", bus.stall_req, bus.data_req); end
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hDEAD_BEEF;
        tick();
        bus.data_data_ok = 1'b0;
        n_chk++; if (bus.stall_req !== 1'b0 || bus.data_req !== 1'b0) begin n_fail++; $display("FAIL rstw_ctrl got stall=%b req=%b exp 0/0", bus.stall_req, bus.data_req); end
        n_chk++; if (bus.wb_valid !== 2'b00 || bus.wb_exc !== 2'b00) begin n_fail++; $display("FAIL rstw_wb got valid=%b exc=%b exp 00/00", bus.wb_valid, bus.wb_exc); end
        n_chk++; if (bus.wb_data !== 64'h0 || bus.wb_reg !== 10'h0) begin n_fail++; $display("FAIL rstw_wb_data got %h reg %h exp 0/0", bus.wb_data, bus.wb_reg); end
        n_chk++; if (bus.data_addr !== 32'h0 || bus.data_wstrb !== 4'h0) begin n_fail++; $display("FAIL rstw_bus got addr=%h strb=%b exp 0/0000", bus.data_addr, bus.data_wstrb); end
        tick();
        n_chk++; if (bus.wb_valid !== 2'b00 || bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL rstw_idle got valid=%b stall=%b exp 00/0", bus.wb_valid, bus.stall_req); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        clear_in();
        test_reset();
        test_alu();
        test_lb_sign();
        test_sh_lw();
        test_sb_slot1();
        test_lh_zero();
        test_misaligned();
        test_rst_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 in_valid  input  [1:0]  per-slot instruction valid from the EX/MEM register; slot 0 is older.
REQ-004 in_load, in_store  input  [1:0] each  per-slot memory operation type; both set is illegal and treated as load.
REQ-005 in_size  input  [1:0][1:0]  access size per slot: 0 byte, 1 half, 2 word.
REQ-006 in_sign  input  [1:0]  sign-extend load result per slot.
REQ-007 in_addr, in_wdata, in_alu  input  [1:0][31:0] each  effective address, store data, and non-memory result per slot.
REQ-008 in_wreg  input  [1:0][4:0]  destination register per slot; 0 means no writeback.
REQ-009 stall_req  output  1  hold the EX/MEM register (its stall input).
REQ-010 data_req, data_wr  output  1 each  bus request and write flag.
REQ-011 data_addr, data_wdata  output  32 each; data_wstrb  output  4.
REQ-012 data_addr_ok, data_data_ok  input  1 each; data_rdata  input  32.
REQ-013 wb_valid  output  [1:0]; wb_reg  output  [1:0][4:0]; wb_data  output  [1:0][31:0]; wb_exc  output  [1:0] (address error).

Function
REQ-014 FSM states IDLE, REQ, WAIT, DONE; slot index k (1 bit) selects the active slot.
REQ-015 A slot is a mem op when in_valid and (in_load or in_store) are set and it is not misaligned; it is misaligned when half has addr[0]=1, or word has addr[1:0]!=0.
REQ-016 Misaligned slot: wb_exc=1, wb_valid=0, no bus request; if slot 0 is misaligned, slot 1 is suppressed (wb_valid[1]=0, wb_exc[1]=0, no request).
REQ-017 IDLE with no mem op in the bundle: stall_req=0; wb_* registered at the next edge (1-cycle latency); FSM stays IDLE.
REQ-018 IDLE with a mem op: stall_req=1; k = lowest mem-op slot; next state REQ.
REQ-019 REQ: data_req=1; address, wdata, wstrb, and wr are driven from slot k; data_addr_ok=1 moves to WAIT; otherwise stay in REQ with outputs stable.
REQ-020 WAIT: data_req=0; on data_data_ok, capture data_rdata for slot k (loads) or just the ack (stores); if slot 1 has an unserviced mem op and k=0, set k=1 and go to REQ, else go to DONE.
REQ-021 stall_req=1 in REQ and WAIT; stall_req=0 in DONE; DONE latches wb_* at its edge and goes to IDLE.
REQ-022 data_addr = in_addr[k] with bits [1:0] kept; wstrb: byte 4'b0001<<a[1:0], half 4'b0011<<a[1:0], word 4'b1111; loads drive wstrb=0.
REQ-023 Store data is replicated across lanes: byte {4{b}}, half {2{h}}.
REQ-024 Load result: select lane by a[1:0]; zero- or sign-extend to 32 per in_sign.
REQ-025 Non-memory valid slot: wb_data=in_alu; a store gives wb_valid=1 with wb_reg forced to 0.
REQ-026 wb_valid[i] = in_valid[i] and not suppressed and not excepting; wb_* hold their last value while stall_req=1 (no duplicate writeback).
REQ-027 data_addr_ok and data_data_ok in the same cycle in REQ are treated as addr_ok only; data_ok is accepted only in WAIT.
REQ-028 Inputs are sampled fresh each cycle; they must stay stable while stall_req=1 (guaranteed by the upstream hold).

Reset
REQ-029 On rst: FSM=IDLE, k=0, data_req=0, stall_req=0, wb_valid=0, wb_exc=0, wb_reg=0, wb_data=0, captured load data=0.
REQ-030 rst mid-transaction aborts to IDLE; any late data_data_ok arriving in IDLE is ignored.

Verification
REQ-031 Two ALU slots, wreg 3/4, alu 5/6 -> stall_req never set; next cycle wb_valid=2'b11, wb_data=5/6.
REQ-032 Slot0 lb addr 0x1003 sign=1, rdata 0x80xxxxxx, addr_ok after 2 cycles, data_ok after 1 more -> stall held through WAIT; wb_data[0]=0xFFFFFF80.
REQ-033 Slot0 sh addr 0x2002 data 0xBEEF, slot1 lw addr 0x3000 -> two serial requests: wstrb 1100 / wdata 0xBEEFBEEF, then wstrb 0000; wb_valid=2'b11 after DONE.
REQ-034 Slot0 lw addr 0x4001 -> no data_req; wb_exc[0]=1; slot1 suppressed; stall_req=0.
REQ-035 rst asserted in WAIT, then data_data_ok the next cycle -> FSM IDLE, all outputs 0, no wb_valid pulse.
